// File: rtl/rbz_spi_loader_pkg.sv
// Shared constants for the raybox-zero SPI loader: register offsets, CTRL bit
// positions, shifter FSM states, reset defaults and a byte-lane merge helper.
// No logic, no latency, no backpressure.
package rbz_spi_loader_pkg;

  localparam logic [3:0] OFS_DATA0 = 4'h0;
  localparam logic [3:0] OFS_DATA1 = 4'h4;
  localparam logic [3:0] OFS_DATA2 = 4'h8;
  localparam logic [3:0] OFS_CTRL  = 4'hC;

  localparam int CTRL_GO      = 0;   // write: start; read: busy
  localparam int CTRL_TGT     = 1;
  localparam int CTRL_LEN_LSB = 2;   // 7-bit len-1 field
  localparam int CTRL_ERR     = 9;
  localparam int CTRL_DONE    = 10;  // read: done; write 1: clear err
  localparam int CTRL_ERR_CLR = 10;
  localparam int CTRL_IRQ_EN  = 11;
  localparam int CTRL_DIV_LSB = 16;

  localparam int         LEN_W      = 7;
  localparam logic [6:0] LEN_M1_MAX = 7'd95;
  localparam logic [7:0] DIV_RST    = 8'd3;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} spi_state_t;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] w;
    w = old_w;
    for (int i = 0; i < 4; i++)
      if (sel[i]) w[8*i +: 8] = new_w[8*i +: 8];
    return w;
  endfunction

endpackage

// File: rtl/rbz_spi_loader_if.sv
// Classic Wishbone slave bus bundle for the SPI loader.
// Latency: none (wires only).  Backpressure: slave acks one cycle after strobe.
// Ports: stb/cyc/we/sel/adr/dat from master; ack/dat back from slave.
interface rbz_spi_loader_if;
  logic        i_wb_stb;
  logic        i_wb_cyc;
  logic        i_wb_we;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;

  modport master (output i_wb_stb, i_wb_cyc, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
                  input  o_wb_ack, o_wb_dat);
  modport slave  (input  i_wb_stb, i_wb_cyc, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
                  output o_wb_ack, o_wb_dat);
endinterface

// File: rtl/rbz_spi_loader_shifter.sv
// SPI mode-0 frame serialiser: FSM, half-period divider, bit counter, shift register.
// Latency: busy rises the cycle after start; frame lasts (2*len+3)*(div+1) cycles.
// Backpressure: start is ignored unless idle; outputs are decoded from state.
module rbz_spi_loader_shifter
  import rbz_spi_loader_pkg::*;
#(
  parameter int BUF_BITS = 96,
  parameter int DIV_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BUF_BITS-1:0] load_dat,
  input  logic [LEN_W-1:0]    len_m1,
  input  logic [DIV_W-1:0]    div,
  output logic                busy,
  output logic                done,
  output logic                csb,
  output logic                sclk,
  output logic                mosi
);

  spi_state_t          state, state_nxt;
  logic [DIV_W-1:0]    hcnt;
  logic [LEN_W-1:0]    bitcnt;
  logic [BUF_BITS-1:0] shreg;
  logic                tick;
  logic [LEN_W-1:0]    len;

  // tick marks the last cycle of the current half-period
  assign tick = (hcnt == div);
  assign len  = len_m1 + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SETUP;
      SETUP: if (tick)  state_nxt = HIGH;
      HIGH:  if (tick)  state_nxt = LOW;
      // bitcnt was bumped on entry to LOW, so it already counts this bit
      LOW:   if (tick)  state_nxt = (bitcnt == len) ? HOLD : HIGH;
      HOLD:  if (tick)  state_nxt = GAP;
      GAP:   if (tick)  state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      if (state == IDLE || state_nxt != state) hcnt <= '0;
      else                                      hcnt <= hcnt + DIV_W'(1);
      if (state == IDLE && start) begin
        shreg  <= load_dat;
        bitcnt <= '0;
      end else if (state == HIGH && tick) begin
        // falling SCLK edge: present the next bit
        shreg  <= {shreg[BUF_BITS-2:0], 1'b0};
        bitcnt <= bitcnt + LEN_W'(1);
      end
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    csb  = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    done = 1'b0;
    case (state)
      SETUP, LOW, HOLD: begin
        csb  = 1'b0;
        mosi = shreg[BUF_BITS-1];
      end
      HIGH: begin
        csb  = 1'b0;
        sclk = 1'b1;
        mosi = shreg[BUF_BITS-1];
      end
      GAP:     done = tick;
      default: ;
    endcase
  end

endmodule

// File: rtl/rbz_spi_loader.sv
// Wishbone-slave SPI master that drives raybox-zero vec/reg SPI inputs from firmware.
// Latency: ack one cycle after strobe; frame starts the cycle after the go ack.
// Backpressure: bus writes while a frame is in flight are acked, dropped and flag err.
// Ports: i_clk/i_reset_n, wb (Wishbone slave), vec/reg csb/sclk/mosi, o_busy, o_irq.
// Option: define RBZ_SPI_LOADER_IRQ_EN for CTRL[11] irq_en and a done-level o_irq.
module rbz_spi_loader
  import rbz_spi_loader_pkg::*;
#(
  parameter int          BUF_BITS  = 96,
  parameter int          DIV_W     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  rbz_spi_loader_if.slave wb,
  output logic           o_vec_csb,
  output logic           o_vec_sclk,
  output logic           o_vec_mosi,
  output logic           o_reg_csb,
  output logic           o_reg_sclk,
  output logic           o_reg_mosi,
  output logic           o_busy,
  output logic           o_irq
);

  logic [BUF_BITS-1:0] data_buf;
  logic [LEN_W-1:0]    len_m1;
  logic [DIV_W-1:0]    div;
  logic                target, err, done, start, irq_en;
  logic                hit, wr, rd, busy_any;
  logic                sh_done, sh_csb, sh_sclk, sh_mosi;
  logic [3:0]          ofs;
  logic [31:0]         rdata, ctrl_word, wdat;
  logic                unused_adr;

  assign ofs        = {wb.i_wb_adr[3:2], 2'b00};
  assign unused_adr = ^wb.i_wb_adr[1:0];
  assign wdat       = wb.i_wb_dat;
  // !ack keeps a held strobe from producing back-to-back acks
  assign hit = wb.i_wb_stb & wb.i_wb_cyc & ~wb.o_wb_ack &
               (wb.i_wb_adr[31:4] == BASE_ADDR[31:4]);
  assign wr  = hit &  wb.i_wb_we;
  assign rd  = hit & ~wb.i_wb_we;
  // start covers the one cycle between the go ack and the shifter leaving IDLE
  assign busy_any = start | o_busy;

  always_comb begin
    ctrl_word                            = '0;
    ctrl_word[CTRL_GO]                   = busy_any;
    ctrl_word[CTRL_TGT]                  = target;
    ctrl_word[CTRL_LEN_LSB +: LEN_W]     = len_m1;
    ctrl_word[CTRL_ERR]                  = err;
    ctrl_word[CTRL_DONE]                 = done;
    ctrl_word[CTRL_IRQ_EN]               = irq_en;
    ctrl_word[CTRL_DIV_LSB +: DIV_W]     = div;
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_DATA0: rdata = data_buf[BUF_BITS-1  -: 32];
      OFS_DATA1: rdata = data_buf[BUF_BITS-33 -: 32];
      OFS_DATA2: rdata = data_buf[BUF_BITS-65 -: 32];
      OFS_CTRL:  rdata = ctrl_word;
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_dat <= '0;
      data_buf    <= '0;
      target      <= 1'b0;
      len_m1      <= '0;
      div         <= DIV_W'(DIV_RST);
      err         <= 1'b0;
      done        <= 1'b0;
      start       <= 1'b0;
    end else begin
      wb.o_wb_ack <= hit;
      wb.o_wb_dat <= rd ? rdata : '0;
      start       <= 1'b0;
      if (rd && ofs == OFS_CTRL) done <= 1'b0;
      if (wr && busy_any) begin
        err <= 1'b1;
      end else if (wr) begin
        case (ofs)
          OFS_DATA0: data_buf[BUF_BITS-1  -: 32] <=
                       byte_merge(data_buf[BUF_BITS-1  -: 32], wdat, wb.i_wb_sel);
          OFS_DATA1: data_buf[BUF_BITS-33 -: 32] <=
                       byte_merge(data_buf[BUF_BITS-33 -: 32], wdat, wb.i_wb_sel);
          OFS_DATA2: data_buf[BUF_BITS-65 -: 32] <=
                       byte_merge(data_buf[BUF_BITS-65 -: 32], wdat, wb.i_wb_sel);
          OFS_CTRL: begin
            target <= wdat[CTRL_TGT];
            len_m1 <= wdat[CTRL_LEN_LSB +: LEN_W];
            if (wb.i_wb_sel[2]) div <= wdat[CTRL_DIV_LSB +: DIV_W];
            if (wdat[CTRL_ERR_CLR]) err <= 1'b0;
            if (wdat[CTRL_GO]) begin
              if (wdat[CTRL_LEN_LSB +: LEN_W] > LEN_M1_MAX) begin
                err <= 1'b1;
              end else begin
                done  <= 1'b0;
                start <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
      // frame completion wins over a same-cycle CTRL read
      if (sh_done) done <= 1'b1;
    end
  end

`ifdef RBZ_SPI_LOADER_IRQ_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                             irq_en <= 1'b0;
    else if (wr && !busy_any && ofs == OFS_CTRL) irq_en <= wdat[CTRL_IRQ_EN];
  end
  assign o_irq = done & irq_en;
`else
  assign irq_en = 1'b0;
  assign o_irq  = 1'b0;
`endif

  rbz_spi_loader_shifter #(
    .BUF_BITS (BUF_BITS),
    .DIV_W    (DIV_W)
  ) u_shifter (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .start    (start),
    .load_dat (data_buf),
    .len_m1   (len_m1),
    .div      (div),
    .busy     (o_busy),
    .done     (sh_done),
    .csb      (sh_csb),
    .sclk     (sh_sclk),
    .mosi     (sh_mosi)
  );

  // the unselected target is parked at csb=1, sclk=0, mosi=0
  assign o_vec_csb  = target | sh_csb;
  assign o_vec_sclk = ~target & sh_sclk;
  assign o_vec_mosi = ~target & sh_mosi;
  assign o_reg_csb  = ~target | sh_csb;
  assign o_reg_sclk = target & sh_sclk;
  assign o_reg_mosi = target & sh_mosi;

endmodule
